// File: rtl/scaler_sfft_decoder.sv
// ============================================================================
// Module      : scaler_sfft_decoder
// Description : Counts ones per lane on unary real/imag bitstreams over a
//               window of 2^BITWIDTH qualified samples and holds the result
//               until the downstream consumer accepts it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scaler_sfft_decoder #(
    parameter int BITWIDTH  = 8,
    parameter int NUMINPUTS = 8,
    parameter int CNTW      = BITWIDTH + 1
) (
    input  logic                      iClk,
    input  logic                      iRstN,
    input  logic                      iEn,
    input  logic                      iClr,
    input  logic                      iStart,
    input  logic [NUMINPUTS-1:0]      iReal,
    input  logic [NUMINPUTS-1:0]      iImg,
    input  logic                      iReady,
    output logic                      oBusy,
    output logic                      oValid,
    output logic [NUMINPUTS*CNTW-1:0] oRealCnt,
    output logic [NUMINPUTS*CNTW-1:0] oImgCnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [BITWIDTH-1:0] C_SMP_LAST = '1;

    state_t                             state_q,  state_d;
    logic [BITWIDTH-1:0]                smp_q,    smp_d;
    logic [NUMINPUTS-1:0][CNTW-1:0]     acc_re_q, acc_re_d;
    logic [NUMINPUTS-1:0][CNTW-1:0]     acc_im_q, acc_im_d;
    logic [NUMINPUTS-1:0][CNTW-1:0]     res_re_q, res_re_d;
    logic [NUMINPUTS-1:0][CNTW-1:0]     res_im_q, res_im_d;
    logic                               valid_q,  valid_d;

    // Running count including the current bit; this is also what gets
    // captured on the final sample so the last bit is never lost.
    logic [NUMINPUTS-1:0][CNTW-1:0]     sum_re;
    logic [NUMINPUTS-1:0][CNTW-1:0]     sum_im;

    always_comb begin
        for (int k = 0; k < NUMINPUTS; k++) begin
            sum_re[k] = acc_re_q[k] + CNTW'(iReal[k]);
            sum_im[k] = acc_im_q[k] + CNTW'(iImg[k]);
        end
    end

    always_comb begin
        state_d  = state_q;
        smp_d    = smp_q;
        acc_re_d = acc_re_q;
        acc_im_d = acc_im_q;
        res_re_d = res_re_q;
        res_im_d = res_im_q;
        valid_d  = valid_q;

        case (state_q)
            IDLE: begin
                if (iStart) begin
                    state_d  = ACCUM;
                    smp_d    = '0;
                    acc_re_d = '0;
                    acc_im_d = '0;
                end
            end
            ACCUM: begin
                if (iEn) begin
                    acc_re_d = sum_re;
                    acc_im_d = sum_im;
                    smp_d    = smp_q + BITWIDTH'(1);
                    if (smp_q == C_SMP_LAST) begin
                        res_re_d = sum_re;
                        res_im_d = sum_im;
                        valid_d  = 1'b1;
                        state_d  = HOLD;
                    end
                end
            end
            HOLD: begin
                if (valid_q && iReady) begin
                    valid_d = 1'b0;
                    if (iStart) begin
                        state_d  = ACCUM;
                        smp_d    = '0;
                        acc_re_d = '0;
                        acc_im_d = '0;
                    end else begin
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Soft clear overrides everything decided above.
        if (iClr) begin
            state_d  = IDLE;
            smp_d    = '0;
            acc_re_d = '0;
            acc_im_d = '0;
            res_re_d = '0;
            res_im_d = '0;
            valid_d  = 1'b0;
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            state_q  <= IDLE;
            smp_q    <= '0;
            acc_re_q <= '0;
            acc_im_q <= '0;
            res_re_q <= '0;
            res_im_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            smp_q    <= smp_d;
            acc_re_q <= acc_re_d;
            acc_im_q <= acc_im_d;
            res_re_q <= res_re_d;
            res_im_q <= res_im_d;
            valid_q  <= valid_d;
        end
    end

    assign oBusy    = (state_q == ACCUM);
    assign oValid   = valid_q;
    assign oRealCnt = res_re_q;
    assign oImgCnt  = res_im_q;

endmodule

`default_nettype wire

// File: tb/tb_scaler_sfft_decoder.sv
// ============================================================================
// Module      : tb_scaler_sfft_decoder
// Description : Directed and randomized bench for scaler_sfft_decoder against
//               a window-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scaler_sfft_decoder;

    localparam int BW  = 8;
    localparam int N   = 8;
    localparam int CW  = BW + 1;
    localparam int WIN = 1 << BW;

    logic            iClk = 1'b0;
    logic            iRstN, iEn, iClr, iStart, iReady;
    logic [N-1:0]    iReal, iImg;
    logic            oBusy, oValid;
    logic [N*CW-1:0] oRealCnt, oImgCnt;

    scaler_sfft_decoder #(.BITWIDTH(BW), .NUMINPUTS(N), .CNTW(CW)) dut (
        .iClk(iClk), .iRstN(iRstN), .iEn(iEn), .iClr(iClr), .iStart(iStart),
        .iReal(iReal), .iImg(iImg), .iReady(iReady),
        .oBusy(oBusy), .oValid(oValid), .oRealCnt(oRealCnt), .oImgCnt(oImgCnt)
    );

    always #5 iClk = ~iClk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Window-level model: a window is open, samples are tallied per lane,
    // and a finished window's tallies are presented until accepted.
    bit m_open, m_valid;
    int m_cnt;
    int m_re[N], m_im[N], m_ore[N], m_oim[N];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic open_window();
        m_open = 1'b1;
        m_cnt  = 0;
        for (int k = 0; k < N; k++) begin
            m_re[k] = 0;
            m_im[k] = 0;
        end
    endtask

    always @(posedge iClk) begin
        if (!iRstN || iClr) begin
            m_open = 1'b0; m_valid = 1'b0; m_cnt = 0;
            for (int k = 0; k < N; k++) begin
                m_re[k] = 0; m_im[k] = 0; m_ore[k] = 0; m_oim[k] = 0;
            end
        end else if (m_open) begin
            if (iEn) begin
                for (int k = 0; k < N; k++) begin
                    m_re[k] += int'(iReal[k]);
                    m_im[k] += int'(iImg[k]);
                end
                m_cnt++;
                if (m_cnt == WIN) begin
                    m_ore   = m_re;
                    m_oim   = m_im;
                    m_valid = 1'b1;
                    m_open  = 1'b0;
                end
            end
        end else if (m_valid) begin
            if (iReady) begin
                m_valid = 1'b0;
                if (iStart) open_window();
            end
        end else if (iStart) begin
            open_window();
        end
    end

    logic [N*CW-1:0] exp_re, exp_im;

    always @(negedge iClk) begin
        if (chk_en) begin
            for (int k = 0; k < N; k++) begin
                exp_re[k*CW +: CW] = CW'(m_ore[k]);
                exp_im[k*CW +: CW] = CW'(m_oim[k]);
            end
            check("model_valid", 128'(oValid), 128'(m_valid));
            check("model_busy",  128'(oBusy),  128'(m_open));
            check("model_real",  128'(oRealCnt), 128'(exp_re));
            check("model_img",   128'(oImgCnt),  128'(exp_im));
        end
    end

    task automatic step(input bit en, input bit clr, input bit start, input bit ready,
                        input logic [N-1:0] re, input logic [N-1:0] im);
        @(negedge iClk);
        iEn = en; iClr = clr; iStart = start; iReady = ready;
        iReal = re; iImg = im;
    endtask

    logic [N*CW-1:0] all256;
    logic [N-1:0]    rv;
    int              q;

    initial begin
        iRstN = 1'b0; iEn = 1'b0; iClr = 1'b0; iStart = 1'b0; iReady = 1'b0;
        iReal = '0; iImg = '0;
        for (int k = 0; k < N; k++) all256[k*CW +: CW] = CW'(WIN);

        step(0, 0, 0, 0, '0, '0);
        step(0, 0, 0, 0, '0, '0);
        chk_en = 1'b1;
        check("reset_valid", 128'(oValid), 128'(0));
        check("reset_busy",  128'(oBusy),  128'(0));
        check("reset_real",  128'(oRealCnt), 128'(0));
        @(negedge iClk) iRstN = 1'b1;

        // Single hot lane, consumer always ready.
        step(0, 0, 1, 1, '0, '0);
        for (int i = 0; i < WIN; i++) begin
            step(1, 0, 0, 1, 8'h01, 8'h00);
            if (i == WIN - 1) check("t1_latency", 128'(oValid), 128'(0));
        end
        step(0, 0, 0, 1, '0, '0);
        check("t1_valid", 128'(oValid), 128'(1));
        check("t1_lane0", 128'(oRealCnt[0 +: CW]), 128'(256));
        check("t1_others", 128'(oRealCnt[N*CW-1:CW]), 128'(0));
        check("t1_img", 128'(oImgCnt), 128'(0));
        step(0, 0, 0, 0, '0, '0);
        check("t1_pulse", 128'(oValid), 128'(0));

        // Lane 3 toggling per qualified sample, stalls every fourth cycle.
        step(0, 0, 1, 1, '0, '0);
        q = 0;
        for (int c = 0; c < 2000 && q < WIN; c++) begin
            rv = N'($urandom);
            if (c % 4 != 3) begin
                rv[3] = (q % 2 == 0);
                step(1, 0, 0, 1, rv, N'($urandom));
                q++;
            end else begin
                step(0, 0, 0, 1, rv, N'($urandom));
            end
            check("t2_busy", 128'(oBusy), 128'(1));
        end
        step(0, 0, 0, 1, '0, '0);
        check("t2_valid", 128'(oValid), 128'(1));
        check("t2_lane3", 128'(oRealCnt[3*CW +: CW]), 128'(128));

        // Consumer stalls; starts during the stall are ignored.
        step(0, 0, 1, 0, '0, '0);
        for (int i = 0; i < WIN; i++) step(1, 0, 0, 0, N'($urandom), N'($urandom));
        for (int i = 0; i < 10; i++) begin
            step(0, 0, i[0], 0, '0, '0);
            check("t3_hold", 128'(oValid), 128'(1));
        end
        step(0, 0, 0, 1, '0, '0);
        check("t3_hold_last", 128'(oValid), 128'(1));
        step(0, 0, 0, 0, '0, '0);
        check("t3_release", 128'(oValid), 128'(0));
        check("t3_idle", 128'(oBusy), 128'(0));

        // Back-to-back windows via start+ready in HOLD.
        step(0, 0, 1, 0, '0, '0);
        for (int i = 0; i < WIN; i++) step(1, 0, 0, 0, N'($urandom), 8'h00);
        step(0, 0, 1, 1, '0, '0);
        check("t4_valid", 128'(oValid), 128'(1));
        for (int i = 0; i < WIN; i++) begin
            step(1, 0, 0, 0, 8'h00, 8'hFF);
            if (i == 0) check("t4_noidle", 128'(oBusy), 128'(1));
        end
        step(0, 0, 0, 1, '0, '0);
        check("t4_real", 128'(oRealCnt), 128'(0));
        check("t4_img", 128'(oImgCnt), 128'(all256));

        // Soft clear mid-window, overriding start/en/ready.
        step(0, 0, 1, 0, '0, '0);
        for (int i = 0; i < 100; i++) step(1, 0, 0, 0, N'($urandom), N'($urandom));
        step(1, 1, 1, 1, 8'hFF, 8'hFF);
        step(0, 0, 0, 0, '0, '0);
        check("t5_valid", 128'(oValid), 128'(0));
        check("t5_busy", 128'(oBusy), 128'(0));
        check("t5_cnt", 128'({oRealCnt, oImgCnt}), 128'(0));
        step(0, 0, 1, 0, '0, '0);
        for (int i = 0; i < WIN; i++) step(1, 0, 0, 0, N'($urandom), N'($urandom));
        step(0, 0, 0, 1, '0, '0);
        check("t5_valid2", 128'(oValid), 128'(1));

        // Reset mid-window together with clear.
        step(0, 0, 1, 0, '0, '0);
        for (int i = 0; i < 50; i++) step(1, 0, 0, 0, N'($urandom), N'($urandom));
        @(negedge iClk);
        iRstN = 1'b0; iClr = 1'b1; iStart = 1'b1; iEn = 1'b1;
        step(0, 0, 0, 0, '0, '0);
        check("t6_valid", 128'(oValid), 128'(0));
        check("t6_busy", 128'(oBusy), 128'(0));
        check("t6_cnt", 128'({oRealCnt, oImgCnt}), 128'(0));
        @(negedge iClk) iRstN = 1'b1;
        step(0, 0, 1, 0, '0, '0);
        for (int i = 0; i < WIN; i++) step(1, 0, 0, 0, 8'hA5, N'($urandom));
        step(0, 0, 0, 1, '0, '0);
        check("t6_lane0", 128'(oRealCnt[0 +: CW]), 128'(256));
        check("t6_lane1", 128'(oRealCnt[CW +: CW]), 128'(0));

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            step(($urandom % 5) != 0, ($urandom % 600) == 0, ($urandom % 8) == 0,
                 ($urandom % 2) == 0, N'($urandom), N'($urandom));
        end

        step(0, 0, 0, 0, '0, '0);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/scaler_sfft_decoder.md
SCALER_SFFT_DECODER -- requirements
Module: scaler_sfft_decoder

Interface
REQ-001 SHALL have parameter BITWIDTH, default 8, meaning log2 of the window length in cycles.
REQ-002 SHALL have parameter NUMINPUTS, default 8, meaning the number of FFT output lanes (real and imaginary each).
REQ-003 SHALL have parameter CNTW, default BITWIDTH+1, meaning the per-lane count width.
REQ-004 SHALL have port iClk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port iRstN  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port iEn  input  1  sample-valid qualifier for the incoming bitstreams.
REQ-007 SHALL have port iClr  input  1  synchronous soft clear.
REQ-008 SHALL have port iStart  input  1  single-cycle request to begin a window.
REQ-009 SHALL have port iReal  input  NUMINPUTS  real-part unary bitstreams, one bit per lane per cycle.
REQ-010 SHALL have port iImg  input  NUMINPUTS  imaginary-part unary bitstreams.
REQ-011 SHALL have port iReady  input  1  downstream accepts the result.
REQ-012 SHALL have port oBusy  output  1  high while in ACCUM.
REQ-013 SHALL have port oValid  output  1  result registers hold a complete window.
REQ-014 SHALL have port oRealCnt  output  NUMINPUTS*CNTW  per-lane ones counts; lane k at bits [k*CNTW +: CNTW].
REQ-015 SHALL have port oImgCnt  output  NUMINPUTS*CNTW  same packing for the imaginary parts.

Function
REQ-016 SHALL implement FSM states IDLE, ACCUM, HOLD.
REQ-017 IDLE: iStart=1 SHALL zero all lane counters and the sample counter, then go to ACCUM; iEn is ignored in IDLE.
REQ-018 ACCUM, iEn=1: each lane counter SHALL add its input bit (0/1); the BITWIDTH-bit sample counter SHALL increment.
REQ-019 ACCUM, iEn=0: all counters SHALL hold (stall); the window is not shortened.
REQ-020 ACCUM, iEn=1 with sample counter = 2^BITWIDTH-1: lane counts including the current bit SHALL load into oRealCnt/oImgCnt, oValid SHALL rise on the next cycle, and the state SHALL go to HOLD.
REQ-021 Latency SHALL be 1 cycle from the last qualified sample to oValid=1; a window is exactly 2^BITWIDTH qualified samples.
REQ-022 Counts SHALL range 0..2^BITWIDTH with no wrap; CNTW bits cover the all-ones case.
REQ-023 HOLD: oRealCnt/oImgCnt/oValid SHALL stay stable until oValid&iReady.
REQ-024 HOLD with iReady=1 and iStart=0 SHALL clear oValid and go to IDLE; with iReady=1 and iStart=1, it SHALL clear oValid and go directly to ACCUM with zeroed counters.
REQ-025 iStart in ACCUM, or in HOLD without iReady, SHALL be ignored.
REQ-026 iClr=1 SHALL, in any state, zero all counters and result registers, drop oValid, and go to IDLE; it overrides iStart, iEn and iReady.
REQ-027 oBusy SHALL be 1 exactly when the state is ACCUM.
REQ-028 iReal/iImg SHALL be sampled only when state=ACCUM and iEn=1.

Reset
REQ-029 iRstN=0 at a clock edge SHALL force IDLE, oValid=0, oBusy=0, oRealCnt=0, oImgCnt=0, and all internal counters to 0.
REQ-030 Reset SHALL take priority over iClr and all other inputs; reset mid-window SHALL discard the partial window with no result emitted.

Verification
REQ-031 Defaults, iStart, iEn=1 for 256 cycles, iReal=8'h01, iImg=8'h00, iReady=1 -> one oValid pulse 1 cycle after the 256th sample; lane0 real=256, all others 0.
REQ-032 Lane 3 real toggling 1,0,1,0,... and iEn deasserted on every 4th cycle -> oValid only after 256 qualified samples; lane3 real=128; oBusy high throughout.
REQ-033 Result with iReady=0 for 10 cycles, then 1 -> oValid and counts stable for 11 cycles, then oValid=0; iStart during the stall is ignored.
REQ-034 iStart and iReady asserted together in HOLD -> the new window starts with no idle cycle; the second window's counts are independent of the first.
REQ-035 iClr at sample 100 -> IDLE, all outputs 0, no oValid; the next iStart window counts from 0.
REQ-036 iRstN=0 at sample 50 with iClr=1 simultaneously -> reset state as in REQ-029; recovery and a full window produce correct counts.
